wb_stage: RTL
=============

Name: wb_stage

Overview:
- Consumer end of the MEM/WB pipeline register.
- Takes the fields latched in MEM/WB, builds the writeback value (ALU result, branch flag, U-immediate, PC+4, or aligned and extended load data), and commits it to a 32x32 register file.
- Provides the ID stage with two read ports that bypass a same-cycle write.
- Exports the commit for forwarding and keeps a retired-instruction counter.

Parameters:
- CNT_W, 64, width of the retired-instruction counter.
- NUM_REGS, 32, register-file depth. x0 is hardwired to zero.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-low.
- wb_advance  in  1  the MEM/WB register loads this cycle, so the current MEM/WB contents retire at this edge.
- memwb_valid  in  1  MEM/WB holds a real instruction (low for a bubble).
- memwb_load_regfile  in  1  the instruction writes rd.
- memwb_regfilemux_sel  in  4  regfilemux_sel_t; selects the writeback source.
- memwb_rd  in  5  destination register.
- memwb_u_imm  in  32  U-type immediate.
- memwb_br_en  in  1  comparison result.
- memwb_rdata  in  32  word-aligned data-memory read data.
- memwb_alu_out  in  32  ALU result / effective address.
- memwb_pc  in  32  PC of the instruction.
- rs1_addr  in  5  ID read-port 1 address.
- rs2_addr  in  5  ID read-port 2 address.
- rs1_data  out  32  read-port 1 data.
- rs2_data  out  32  read-port 2 data.
- wb_we  out  1  a register write commits at this edge.
- wb_rd  out  5  destination of the write.
- wb_data  out  32  writeback value.
- retire_count  out  CNT_W  number of instructions retired.

Behaviour:
- commit = memwb_valid & wb_advance. Evaluated combinationally every cycle.
- wb_we = commit & memwb_load_regfile & (memwb_rd != 0).
- wb_rd = memwb_rd.
- wb_data is combinational from memwb_regfilemux_sel:
  - ALU: alu_out.
  - BR_EN: {31'b0, br_en}.
  - U_IMM: u_imm.
  - PC_PLUS4: pc + 4, wrapping modulo 2^32.
  - LW: rdata. alu_out[1:0] is ignored.
  - LB / LBU: byte selected by alu_out[1:0]; sign- or zero-extended.
  - LH / LHU: halfword selected by alu_out[1]; alu_out[0] is ignored; sign- or zero-extended.
  - Undefined codes (9-15): alu_out.
- Register file:
  - Written at the rising clk edge when wb_we is high.
  - x0 reads 0 always, and a write to x0 is dropped.
- Read ports:
  - Combinational.
  - If wb_we is high and rsN_addr == wb_rd (nonzero), rsN_data = wb_data (write-first bypass).
  - Otherwise rsN_data is the stored value.
- retire_count:
  - Increments by 1 at each edge where commit is high, whether or not rd is written.
  - Wraps at 2^CNT_W.
- Stall: MEM/WB may hold the same instruction for many cycles with wb_advance low.
  - The register file is not written while wb_advance is low.
  - retire_count does not change while wb_advance is low.
  - The instruction commits exactly once, on the cycle wb_advance rises.
- Bubble (memwb_valid low): no write, no count; wb_we = 0.
- Reset (rst low, asynchronous):
  - All registers clear to 0 and retire_count = 0 immediately.
  - While in reset: wb_we forced 0, and rs1_data / rs2_data read 0.
  - A write whose edge coincides with reset assertion is dropped.
  - After rst is released, operation resumes on the first rising edge.
- Latency:
  - A value written at edge N is visible combinationally in cycle N (bypass).
  - From the array it is visible from cycle N+1 onward.

Decomposition:
- Package wb_types:
  - regfilemux_sel_t enum: ALU=0, BR_EN=1, U_IMM=2, LW=3, PC_PLUS4=4, LB=5, LBU=6, LH=7, LHU=8.
  - Constant REG_ZERO = 5'd0.
- Sub-module regfile_2r1w:
  - Array with async active-low clear.
  - One write port, two combinational read ports, with the bypass and the x0 rule.
- The load extender and the counter stay in wb_stage.

Test Plan:
- Reset: rst low for 2 cycles with wb_advance=1, valid=1 -> wb_we=0, retire_count=0; after release, reading x5 returns 0.
- ALU write with bypass: rd=5, sel=ALU, alu_out=0xDEADBEEF, valid=1, advance=1, rs1_addr=5 -> same cycle rs1_data=0xDEADBEEF; next cycle, with sel changed, x5 still reads 0xDEADBEEF.
- x0: rd=0, load_regfile=1, alu_out=0x12345678, commit -> wb_we=0, x0 reads 0, retire_count increments by 1.
- Loads, rdata=0x8070F0A1:
  - LB, offset 2 -> 0x00000070.
  - LB, offset 1 -> 0xFFFFFFF0.
  - LH, offset 2 -> 0xFFFF8070.
  - LHU, offset 0 -> 0x0000F0A1.
  - LW, offset 3 -> 0x8070F0A1.
- Stall: valid=1, rd=7, sel=PC_PLUS4, pc=0xFFFFFFFC, with advance=0 for 3 cycles then 1 -> x7=0x00000000, retire_count increments by exactly 1, and wb_we is high for exactly one cycle.
- Mid-operation reset: rst dropped asynchronously between edges while x3 holds 0xA5A5A5A5 and a write to x4 is pending -> x3 and x4 read 0 and retire_count=0 immediately, before the next edge.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - writeback-source encoding and shared constants for wb_stage
package wb_types;

    typedef enum logic [3:0] {
        ALU      = 4'd0,
        BR_EN    = 4'd1,
        U_IMM    = 4'd2,
        LW       = 4'd3,
        PC_PLUS4 = 4'd4,
        LB       = 4'd5,
        LBU      = 4'd6,
        LH       = 4'd7,
        LHU      = 4'd8
    } regfilemux_sel_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM/WB fields, ID read ports and commit export of the writeback stage
interface wb_stage_if #(
    parameter int CNT_W = 64
);
    logic             wb_advance;
    logic             memwb_valid;
    logic             memwb_load_regfile;
    logic [3:0]       memwb_regfilemux_sel;
    logic [4:0]       memwb_rd;
    logic [31:0]      memwb_u_imm;
    logic             memwb_br_en;
    logic [31:0]      memwb_rdata;
    logic [31:0]      memwb_alu_out;
    logic [31:0]      memwb_pc;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output wb_advance, memwb_valid, memwb_load_regfile, memwb_regfilemux_sel,
               memwb_rd, memwb_u_imm, memwb_br_en, memwb_rdata, memwb_alu_out,
               memwb_pc, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_we, wb_rd, wb_data, retire_count
    );

    modport slave (
        input  wb_advance, memwb_valid, memwb_load_regfile, memwb_regfilemux_sel,
               memwb_rd, memwb_u_imm, memwb_br_en, memwb_rdata, memwb_alu_out,
               memwb_pc, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_we, wb_rd, wb_data, retire_count
    );

endinterface

// File: rtl/wb_stage_regfile.sv
// rtl/wb_stage_regfile.sv - 2-read/1-write register file, x0 hardwired, write-first bypass
module regfile_2r1w
    import wb_types::*;
#(
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr1_i,
    input  logic [AW-1:0] raddr2_i,
    output logic [31:0]   rdata1_o,
    output logic [31:0]   rdata2_o
);

    logic [31:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_ZERO[AW-1:0])) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [31:0] read_port(input logic [AW-1:0] addr);
        if (!rst_n || addr == REG_ZERO[AW-1:0]) begin
            return '0;
        end
        // A write committing this cycle is visible before it lands in the array.
        if (we_i && addr == waddr_i) begin
            return wdata_i;
        end
        return regs_q[addr];
    endfunction

    assign rdata1_o = read_port(raddr1_i);
    assign rdata2_o = read_port(raddr2_i);

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: result mux, load extension, regfile commit, retire counter
module wb_stage
    import wb_types::*;
#(
    parameter int CNT_W    = 64,
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   bus
);

    logic             commit;
    logic             wb_we;
    logic [31:0]      wb_data;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [CNT_W-1:0] retire_q;
    logic [CNT_W-1:0] retire_d;

    assign commit = bus.memwb_valid & bus.wb_advance;
    assign wb_we  = rst & commit & bus.memwb_load_regfile & (bus.memwb_rd != REG_ZERO);

    assign load_byte = bus.memwb_rdata[{bus.memwb_alu_out[1:0], 3'b000} +: 8];
    assign load_half = bus.memwb_alu_out[1] ? bus.memwb_rdata[31:16] : bus.memwb_rdata[15:0];

    always_comb begin
        wb_data = bus.memwb_alu_out;
        case (regfilemux_sel_t'(bus.memwb_regfilemux_sel))
            ALU:      wb_data = bus.memwb_alu_out;
            BR_EN:    wb_data = {31'b0, bus.memwb_br_en};
            U_IMM:    wb_data = bus.memwb_u_imm;
            PC_PLUS4: wb_data = bus.memwb_pc + 32'd4;
            LW:       wb_data = bus.memwb_rdata;
            LB:       wb_data = {{24{load_byte[7]}}, load_byte};
            LBU:      wb_data = {24'b0, load_byte};
            LH:       wb_data = {{16{load_half[15]}}, load_half};
            LHU:      wb_data = {16'b0, load_half};
            default:  wb_data = bus.memwb_alu_out;
        endcase
    end

    // Bubbles and stalled cycles retire nothing; x0 writes still count.
    assign retire_d = commit ? retire_q + {{(CNT_W-1){1'b0}}, 1'b1} : retire_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    regfile_2r1w #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst),
        .we_i     (wb_we),
        .waddr_i  (bus.memwb_rd),
        .wdata_i  (wb_data),
        .raddr1_i (bus.rs1_addr),
        .raddr2_i (bus.rs2_addr),
        .rdata1_o (bus.rs1_data),
        .rdata2_o (bus.rs2_data)
    );

    assign bus.wb_we        = wb_we;
    assign bus.wb_rd        = bus.memwb_rd;
    assign bus.wb_data      = wb_data;
    assign bus.retire_count = retire_q;

endmodule
